food_manager: RTL and testbench

- Sits directly downstream of the random grid position generator in the VGA snake game.
- Samples the free-running random X/Y candidate and asks the snake body tracker whether that cell is occupied; if it is free, commits it as the food location.
- Detects when the snake head reaches the food, then pulses eaten, increments the score and re-places the food.
- Also produces the registered food pixel flag for the VGA colour mux.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/food_manager_box_overlap.sv | 32 +++
 rtl/food_manager.sv | 167 ++++++++++++++++
 tb/tb_food_manager.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game datapath.
//   GRID_SIZE/X_W/Y_W/SCREEN_*: playfield geometry in pixels
//   CMP_W: width used for box compares (one bit of headroom over X_W)
//   state_e: food placement FSM states
//   pos_t: packed X/Y screen position
package snake_pkg;

  localparam int unsigned GRID_SIZE = 10;
  localparam int unsigned X_W       = 10;
  localparam int unsigned Y_W       = 9;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned CMP_W     = 11;

  typedef enum logic [1:0] {
    SAMPLE = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

endpackage

// File: rtl/food_manager_box_overlap.sv
// Combinational axis-aligned box intersect test.
//   a_x_i/a_y_i : top-left of box A (edge A_SIZE)
//   b_x_i/b_y_i : top-left of box B (edge B_SIZE)
//   overlap_o   : combinational, 1 when the half-open boxes intersect
module box_overlap
  import snake_pkg::*;
#(
  parameter int unsigned A_SIZE = GRID_SIZE,
  parameter int unsigned B_SIZE = GRID_SIZE
) (
  input  logic [X_W-1:0] a_x_i,
  input  logic [Y_W-1:0] a_y_i,
  input  logic [X_W-1:0] b_x_i,
  input  logic [Y_W-1:0] b_y_i,
  output logic           overlap_o
);

  logic [CMP_W-1:0] ax, ay, bx, by;
  logic             x_ov, y_ov;

  // Widen before adding the box size so the end coordinate never wraps.
  assign ax = CMP_W'(a_x_i);
  assign ay = CMP_W'(a_y_i);
  assign bx = CMP_W'(b_x_i);
  assign by = CMP_W'(b_y_i);

  assign x_ov = ((ax + CMP_W'(A_SIZE)) > bx) && ((bx + CMP_W'(B_SIZE)) > ax);
  assign y_ov = ((ay + CMP_W'(A_SIZE)) > by) && ((by + CMP_W'(B_SIZE)) > ay);

  assign overlap_o = x_ov && y_ov;

endmodule

// File: rtl/food_manager.sv
// Food placement, catch detection and scoring for the snake game.
//   rand_X/rand_Y     : free-running candidate position
//   frame_tick        : one pulse per game update
//   head_X/head_Y     : snake head top-left
//   occ_req/occ_X/occ_Y, occ_ack/occ_hit : body occupancy query handshake
//   pixel_X/pixel_Y   : current VGA pixel
//   food_X/food_Y/food_valid : committed food location
//   eaten/score       : catch pulse and saturating catch count
//   food_pixel        : registered "pixel inside food box" flag
module food_manager
  import snake_pkg::*;
#(
  parameter int unsigned FOOD_SIZE = GRID_SIZE,
  parameter int unsigned MAX_RETRY = 4,
  parameter int unsigned SCORE_W   = 8
) (
  input  logic               VGA_clk,
  input  logic               reset,
  input  logic [X_W-1:0]     rand_X,
  input  logic [Y_W-1:0]     rand_Y,
  input  logic               frame_tick,
  input  logic [X_W-1:0]     head_X,
  input  logic [Y_W-1:0]     head_Y,
  output logic               occ_req,
  output logic [X_W-1:0]     occ_X,
  output logic [Y_W-1:0]     occ_Y,
  input  logic               occ_ack,
  input  logic               occ_hit,
  input  logic [X_W-1:0]     pixel_X,
  input  logic [Y_W-1:0]     pixel_Y,
  output logic [X_W-1:0]     food_X,
  output logic [Y_W-1:0]     food_Y,
  output logic               food_valid,
  output logic               eaten,
  output logic [SCORE_W-1:0] score,
  output logic               food_pixel
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e               state_q, state_d;
  pos_t                 occ_q, occ_d;
  pos_t                 food_q, food_d;
  logic                 occ_req_q, occ_req_d;
  logic                 food_valid_q, food_valid_d;
  logic                 eaten_q, eaten_d;
  logic                 food_pixel_q, food_pixel_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;

  logic head_hit_c, pix_hit_c, ack_c, accept_c, catch_c;

  // Head box against food box.
  box_overlap #(.A_SIZE(FOOD_SIZE), .B_SIZE(FOOD_SIZE)) u_head_ov (
    .a_x_i    (head_X),
    .a_y_i    (head_Y),
    .b_x_i    (food_q.x),
    .b_y_i    (food_q.y),
    .overlap_o(head_hit_c)
  );

  // Current pixel treated as a 1x1 box against the food box.
  box_overlap #(.A_SIZE(1), .B_SIZE(FOOD_SIZE)) u_pix_ov (
    .a_x_i    (pixel_X),
    .a_y_i    (pixel_Y),
    .b_x_i    (food_q.x),
    .b_y_i    (food_q.y),
    .overlap_o(pix_hit_c)
  );

  // Acks only count while a query is outstanding; the retry cap forces acceptance.
  assign ack_c    = occ_req_q && occ_ack;
  assign accept_c = ack_c && (!occ_hit || (retry_q == RETRY_W'(MAX_RETRY)));
  assign catch_c  = frame_tick && head_hit_c;

  // State register.
  always_ff @(posedge VGA_clk) begin
    if (reset) state_q <= SAMPLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SAMPLE: state_d = REQ;
      REQ: begin
        if (accept_c)   state_d = ACTIVE;
        else if (ack_c) state_d = SAMPLE;
      end
      ACTIVE: if (catch_c) state_d = SAMPLE;
      default: state_d = SAMPLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    occ_d        = occ_q;
    food_d       = food_q;
    occ_req_d    = occ_req_q;
    food_valid_d = food_valid_q;
    eaten_d      = 1'b0;
    score_d      = score_q;
    retry_d      = retry_q;
    food_pixel_d = food_valid_q && pix_hit_c;
    case (state_q)
      SAMPLE: begin
        occ_d.x   = rand_X;
        occ_d.y   = rand_Y;
        occ_req_d = 1'b1;
      end
      REQ: begin
        if (accept_c) begin
          food_d       = occ_q;
          food_valid_d = 1'b1;
          occ_req_d    = 1'b0;
          retry_d      = '0;
        end else if (ack_c) begin
          occ_req_d = 1'b0;
          retry_d   = retry_q + RETRY_W'(1);
        end
      end
      ACTIVE: begin
        if (catch_c) begin
          eaten_d      = 1'b1;
          food_valid_d = 1'b0;
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
        end
      end
      default: occ_req_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      occ_q        <= '0;
      food_q       <= '0;
      occ_req_q    <= 1'b0;
      food_valid_q <= 1'b0;
      eaten_q      <= 1'b0;
      score_q      <= '0;
      retry_q      <= '0;
      food_pixel_q <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      food_q       <= food_d;
      occ_req_q    <= occ_req_d;
      food_valid_q <= food_valid_d;
      eaten_q      <= eaten_d;
      score_q      <= score_d;
      retry_q      <= retry_d;
      food_pixel_q <= food_pixel_d;
    end
  end

  assign occ_req    = occ_req_q;
  assign occ_X      = occ_q.x;
  assign occ_Y      = occ_q.y;
  assign food_X     = food_q.x;
  assign food_Y     = food_q.y;
  assign food_valid = food_valid_q;
  assign eaten      = eaten_q;
  assign score      = score_q;
  assign food_pixel = food_pixel_q;

endmodule

// File: tb/tb_food_manager.sv
// Self-checking bench for food_manager: an occupancy responder and a
// commit/catch monitor driven from expected-result queues.
module tb_food_manager;

  localparam int unsigned MAX_RETRY = 4;

  logic       VGA_clk;
  logic       reset, frame_tick, occ_ack, occ_hit;
  logic [9:0] rand_X, head_X, occ_X, pixel_X, food_X;
  logic [8:0] rand_Y, head_Y, occ_Y, pixel_Y, food_Y;
  logic       occ_req, food_valid, eaten, food_pixel;
  logic [7:0] score;

  int n_chk, n_pass;
  int ack_dly;
  bit stray_ack;
  int req_rises;

  logic [18:0] cand_q[$];
  logic [18:0] exp_commit[$];
  logic [7:0]  exp_eat[$];
  bit          hit_q[$];

  int pxs[6] = '{109, 110, 100, 100, 99, 105};
  int pys[6] = '{109, 100, 100, 110, 105, 105};
  int pex[6] = '{1, 0, 1, 0, 0, 1};

  food_manager #(.FOOD_SIZE(10), .MAX_RETRY(MAX_RETRY), .SCORE_W(8)) dut (
    .VGA_clk   (VGA_clk),
    .reset     (reset),
    .rand_X    (rand_X),
    .rand_Y    (rand_Y),
    .frame_tick(frame_tick),
    .head_X    (head_X),
    .head_Y    (head_Y),
    .occ_req   (occ_req),
    .occ_X     (occ_X),
    .occ_Y     (occ_Y),
    .occ_ack   (occ_ack),
    .occ_hit   (occ_hit),
    .pixel_X   (pixel_X),
    .pixel_Y   (pixel_Y),
    .food_X    (food_X),
    .food_Y    (food_Y),
    .food_valid(food_valid),
    .eaten     (eaten),
    .score     (score),
    .food_pixel(food_pixel)
  );

  initial begin
    VGA_clk = 1'b0;
    forever #5 VGA_clk = ~VGA_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Occupancy responder: answers each query after ack_dly cycles, using
  // hit_q for the answer, and predicts which candidate gets committed.
  initial begin : responder
    int wait_cnt;
    int m_retry;
    bit need_new;
    bit hit;
    occ_ack = 1'b0; occ_hit = 1'b0; rand_X = '0; rand_Y = '0;
    wait_cnt = 0; m_retry = 0; need_new = 1'b1;
    forever begin
      @(negedge VGA_clk);
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      if (reset) begin
        wait_cnt = 0;
        m_retry  = 0;
      end else if (occ_req) begin
        chk("occ_x", 32'(occ_X), 32'(rand_X));
        chk("occ_y", 32'(occ_Y), 32'(rand_Y));
        if (wait_cnt < ack_dly) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          hit = (hit_q.size() != 0) ? hit_q.pop_front() : 1'b0;
          occ_ack = 1'b1;
          occ_hit = hit;
          if (!hit || m_retry == MAX_RETRY) begin
            exp_commit.push_back({rand_X, rand_Y});
            m_retry = 0;
          end else begin
            m_retry++;
          end
          need_new = 1'b1;
        end
      end else if (stray_ack) begin
        occ_ack = 1'b1;
      end
      if (need_new && cand_q.size() != 0) begin
        {rand_X, rand_Y} = cand_q.pop_front();
        need_new = 1'b0;
      end
    end
  end

  // Monitor: scores commits and catches against the expected queues.
  initial begin : monitor
    logic        prev_valid, prev_req;
    logic [18:0] ec;
    logic [7:0]  es;
    prev_valid = 1'b0; prev_req = 1'b0; req_rises = 0;
    forever begin
      @(negedge VGA_clk);
      if (food_valid && !prev_valid) begin
        chk("commit_expected", 32'(exp_commit.size() != 0), 32'd1);
        if (exp_commit.size() != 0) begin
          ec = exp_commit.pop_front();
          chk("food_x", 32'(food_X), 32'(ec[18:9]));
          chk("food_y", 32'(food_Y), 32'(ec[8:0]));
        end
      end
      if (eaten) begin
        chk("eat_expected", 32'(exp_eat.size() != 0), 32'd1);
        if (exp_eat.size() != 0) begin
          es = exp_eat.pop_front();
          chk("score", 32'(score), 32'(es));
          chk("valid_on_eat", 32'(food_valid), 32'd0);
        end
      end
      if (occ_req && !prev_req) req_rises++;
      prev_valid = food_valid;
      prev_req   = occ_req;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge VGA_clk);
    frame_tick = 1'b1;
    @(negedge VGA_clk);
    frame_tick = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (food_valid !== 1'b1 && n < 200) begin
      @(negedge VGA_clk);
      n++;
    end
    chk(tag, 32'(food_valid), 32'd1);
  endtask

  initial begin : main
    logic [7:0] m_score;
    int base;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; frame_tick = 1'b0; ack_dly = 0; stray_ack = 1'b0;
    head_X = '0; head_Y = '0; pixel_X = '0; pixel_Y = '0;
    m_score = '0;

    // Reset state, then first placement with an immediate free ack.
    cand_q.push_back({10'd200, 9'd150});
    repeat (3) @(negedge VGA_clk);
    chk("rst_occ_req", 32'(occ_req), 32'd0);
    chk("rst_valid", 32'(food_valid), 32'd0);
    chk("rst_food_x", 32'(food_X), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_eaten", 32'(eaten), 32'd0);
    reset = 1'b0;
    @(negedge VGA_clk);
    chk("req_after_sample", 32'(occ_req), 32'd1);
    chk("valid_pending", 32'(food_valid), 32'd0);
    @(negedge VGA_clk);
    chk("req_one_cycle", 32'(occ_req), 32'd0);
    chk("valid_first", 32'(food_valid), 32'd1);

    // X and Y edge boundaries: touching boxes do not overlap.
    head_X = 10'd210; head_Y = 9'd150;
    tick();
    chk("no_eat_x_edge", 32'(eaten), 32'd0);
    head_X = 10'd200; head_Y = 9'd160;
    tick();
    chk("no_eat_y_edge", 32'(eaten), 32'd0);
    chk("score_hold", 32'(score), 32'd0);
    chk("valid_hold", 32'(food_valid), 32'd1);

    // One pixel inside on X is a catch.
    head_X = 10'd209; head_Y = 9'd150;
    cand_q.push_back({10'd200, 9'd150});
    m_score = m_score + 8'd1; exp_eat.push_back(m_score);
    tick();
    chk("eat_x_inside", 32'(eaten), 32'd1);
    wait_valid("place_2");

    // Catch with latency trace: eaten t+1, occ_req t+2, food_valid t+3.
    head_X = 10'd195; head_Y = 9'd155;
    cand_q.push_back({10'd100, 9'd100});
    m_score = m_score + 8'd1; exp_eat.push_back(m_score);
    tick();
    chk("eat_t1", 32'(eaten), 32'd1);
    chk("req_t1", 32'(occ_req), 32'd0);
    @(negedge VGA_clk);
    chk("eaten_one_cycle", 32'(eaten), 32'd0);
    chk("req_t2", 32'(occ_req), 32'd1);
    @(negedge VGA_clk);
    chk("valid_t3", 32'(food_valid), 32'd1);

    // Food pixel at (100,100): registered, one cycle after the pixel.
    for (int i = 0; i < 6; i++) begin
      pixel_X = 10'(pxs[i]);
      pixel_Y = 9'(pys[i]);
      @(negedge VGA_clk);
      chk($sformatf("food_pixel_%0d_%0d", pxs[i], pys[i]), 32'(food_pixel), 32'(pex[i]));
    end

    // Acks with no query outstanding change nothing.
    stray_ack = 1'b1;
    repeat (3) @(negedge VGA_clk);
    stray_ack = 1'b0;
    @(negedge VGA_clk);
    chk("stray_food_x", 32'(food_X), 32'd100);
    chk("stray_valid", 32'(food_valid), 32'd1);

    // Five occupied answers: four resamples, fifth forced; ticks ignored meanwhile.
    head_X = 10'd100; head_Y = 9'd100;
    cand_q.push_back({10'd10, 9'd10});
    cand_q.push_back({10'd20, 9'd20});
    cand_q.push_back({10'd30, 9'd30});
    cand_q.push_back({10'd40, 9'd40});
    cand_q.push_back({10'd320, 9'd240});
    repeat (5) hit_q.push_back(1'b1);
    ack_dly = 2;
    m_score = m_score + 8'd1; exp_eat.push_back(m_score);
    base = req_rises;
    tick();
    chk("eat_retry", 32'(eaten), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tick_ignored", 32'(eaten), 32'd0);
      chk("score_ignored", 32'(score), 32'(m_score));
    end
    wait_valid("place_forced");
    chk("resample_count", 32'(req_rises - base), 32'd5);

    // Retry counter cleared: a single hit then free commits the second candidate.
    ack_dly = 0;
    head_X = 10'd320; head_Y = 9'd240;
    cand_q.push_back({10'd60, 9'd60});
    cand_q.push_back({10'd50, 9'd50});
    hit_q.push_back(1'b1);
    hit_q.push_back(1'b0);
    m_score = m_score + 8'd1; exp_eat.push_back(m_score);
    tick();
    wait_valid("place_after_retry");

    // Drive score to saturation and one past it.
    head_X = 10'd50; head_Y = 9'd50;
    for (int i = 0; i < 252; i++) begin
      m_score = (m_score == 8'hFF) ? 8'hFF : m_score + 8'd1;
      exp_eat.push_back(m_score);
      tick();
      wait_valid("place_sat");
    end
    chk("score_saturated", 32'(score), 32'd255);

    // Reset while a query is outstanding.
    ack_dly = 5;
    exp_eat.push_back(8'hFF);
    tick();
    begin
      int n;
      n = 0;
      while (occ_req !== 1'b1 && n < 20) begin
        @(negedge VGA_clk);
        n++;
      end
      chk("req_before_reset", 32'(occ_req), 32'd1);
    end
    reset = 1'b1;
    @(negedge VGA_clk);
    chk("rreq_occ_req", 32'(occ_req), 32'd0);
    chk("rreq_occ_x", 32'(occ_X), 32'd0);
    chk("rreq_score", 32'(score), 32'd0);
    chk("rreq_valid", 32'(food_valid), 32'd0);
    chk("rreq_food_x", 32'(food_X), 32'd0);
    chk("rreq_food_y", 32'(food_Y), 32'd0);
    chk("rreq_eaten", 32'(eaten), 32'd0);
    chk("rreq_pixel", 32'(food_pixel), 32'd0);
    reset = 1'b0;
    ack_dly = 0;
    wait_valid("place_after_reset");

    @(negedge VGA_clk);
    chk("commit_queue_drained", 32'(exp_commit.size()), 32'd0);
    chk("eat_queue_drained", 32'(exp_eat.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
